// File: rtl/pulse_decoder_4_16_if.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_decoder_4_16_if
//  Purpose  : Handshake and output bundle for the pulse_decoder_4_16 block.
//  Revision : 1.0  initial release
// ============================================================================
interface pulse_decoder_4_16_if #(
    parameter int IN_W = 4
);
    localparam int OUT_W = 2 ** IN_W;

    logic             enable;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in;
    logic [OUT_W-1:0] out;
    logic             out_valid;
    logic             overrun;

    modport master (
        output enable,
        output in_valid,
        output in,
        input  in_ready,
        input  out,
        input  out_valid,
        input  overrun
    );

    modport slave (
        input  enable,
        input  in_valid,
        input  in,
        output in_ready,
        output out,
        output out_valid,
        output overrun
    );
endinterface
`default_nettype wire

// File: rtl/pulse_decoder_4_16.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_decoder_4_16
//  Purpose  : Registered binary-to-one-hot decoder that holds each decoded
//             line for HOLD_CYCLES clocks. Optional sticky overrun flag is
//             built when PULSE_DECODER_OVERRUN_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module pulse_decoder_4_16 #(
    parameter int IN_W        = 4,
    parameter int HOLD_CYCLES = 3
) (
    input  wire                   clk,
    input  wire                   rst_n,
    pulse_decoder_4_16_if.slave   bus
);
    localparam int OUT_W = 2 ** IN_W;
    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [OUT_W-1:0] out_q;
    logic             out_valid_q;
    logic [OUT_W-1:0] decode_d;
    logic             last_d;
    logic             ready_d;
    logic             accept_d;

    // Code k maps to line k-1; code 0 and any unknown code leave all lines low.
    always_comb begin
        decode_d = '0;
        for (int k = 1; k < OUT_W; k++) begin
            if (bus.in == IN_W'(k)) begin
                decode_d[k-1] = 1'b1;
            end
        end
    end

    assign last_d   = (state_q == HOLD) && (cnt_q == CNT_LAST);
    assign ready_d  = bus.enable && ((state_q == IDLE) || last_d);
    assign accept_d = bus.in_valid && ready_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (!bus.enable) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (accept_d) begin
            state_q     <= HOLD;
            cnt_q       <= '0;
            out_q       <= decode_d;
            out_valid_q <= 1'b1;
        end else if (state_q == HOLD) begin
            if (last_d) begin
                state_q     <= IDLE;
                cnt_q       <= '0;
                out_q       <= '0;
                out_valid_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready  = ready_d;
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;

`ifdef PULSE_DECODER_OVERRUN_EN
    logic overrun_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else if (bus.in_valid && bus.enable && !ready_d) begin
            overrun_q <= 1'b1;
        end
    end

    assign bus.overrun = overrun_q;
`else
    assign bus.overrun = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pulse_decoder_4_16.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pulse_decoder_4_16
//  Purpose  : Directed self-checking bench for pulse_decoder_4_16 (HOLD=3).
//  Revision : 1.0  initial release
// ============================================================================
module tb_pulse_decoder_4_16;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    logic [15:0] exp_out;

`ifdef PULSE_DECODER_OVERRUN_EN
    localparam logic OVR_EXP = 1'b1;
`else
    localparam logic OVR_EXP = 1'b0;
`endif

    pulse_decoder_4_16_if #(.IN_W(4)) bus ();

    pulse_decoder_4_16 #(
        .IN_W        (4),
        .HOLD_CYCLES (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        rst_n        = 1'b0;
        bus.enable   = 1'b0;
        bus.in_valid = 1'b0;
        bus.in       = '0;

        // Reset state
        #12;
        chk("rst_out",       32'(bus.out),       32'h0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_overrun",   32'(bus.overrun),   32'h0);
        @(negedge clk);
        rst_n      = 1'b1;
        bus.enable = 1'b1;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'h1);

        // Single accept of code 5
        tick();
        bus.in = 4'h5; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("c5_h1_out",   32'(bus.out),       32'h0010);
        chk("c5_h1_valid", 32'(bus.out_valid), 32'h1);
        chk("c5_h1_ready", 32'(bus.in_ready),  32'h0);
        tick();
        chk("c5_h2_out",   32'(bus.out),       32'h0010);
        chk("c5_h2_ready", 32'(bus.in_ready),  32'h0);
        tick();
        chk("c5_h3_out",   32'(bus.out),       32'h0010);
        chk("c5_h3_ready", 32'(bus.in_ready),  32'h1);
        tick();
        chk("c5_end_out",   32'(bus.out),       32'h0);
        chk("c5_end_valid", 32'(bus.out_valid), 32'h0);
        chk("c5_end_ready", 32'(bus.in_ready),  32'h1);

        // Sweep every code, one full hold each
        for (int k = 0; k < 16; k++) begin
            exp_out = (k == 0) ? 16'h0 : (16'h1 << (k - 1));
            bus.in = 4'(k); bus.in_valid = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            chk($sformatf("sweep%0d_out", k),   32'(bus.out),       32'(exp_out));
            chk($sformatf("sweep%0d_valid", k), 32'(bus.out_valid), 32'h1);
            chk($sformatf("sweep%0d_b15", k),   32'(bus.out[15]),   32'h0);
            tick();
            tick();
            chk($sformatf("sweep%0d_h3", k),    32'(bus.out),       32'(exp_out));
            tick();
            chk($sformatf("sweep%0d_end", k),   32'(bus.out),       32'h0);
        end
        chk("sweep_overrun", 32'(bus.overrun), 32'h0);

        // Offer a code during hold cycle 1
        bus.in = 4'h3; bus.in_valid = 1'b1;
        tick();
        chk("ovr_h1_out", 32'(bus.out), 32'h0004);
        tick();
        bus.in_valid = 1'b0;
        chk("ovr_flag",   32'(bus.overrun), 32'(OVR_EXP));
        chk("ovr_h2_out", 32'(bus.out),     32'h0004);
        tick();
        tick();
        chk("ovr_end_out", 32'(bus.out),     32'h0);
        chk("ovr_sticky",  32'(bus.overrun), 32'(OVR_EXP));

        // Back-to-back: code 1 then code 2 with no gap
        bus.in = 4'h1; bus.in_valid = 1'b1;
        tick();
        chk("b2b_h1", 32'(bus.out), 32'h0001);
        tick();
        chk("b2b_h2", 32'(bus.out), 32'h0001);
        tick();
        chk("b2b_h3", 32'(bus.out), 32'h0001);
        bus.in = 4'h2;
        tick();
        bus.in_valid = 1'b0;
        chk("b2b_next_out",   32'(bus.out),       32'h0002);
        chk("b2b_next_valid", 32'(bus.out_valid), 32'h1);
        tick();
        tick();
        chk("b2b_next_h3", 32'(bus.out), 32'h0002);
        tick();
        chk("b2b_end", 32'(bus.out), 32'h0);

        // Same code back-to-back extends the hold
        bus.in = 4'h7; bus.in_valid = 1'b1;
        tick(); tick(); tick(); tick();
        bus.in_valid = 1'b0;
        chk("ext_h4_out",   32'(bus.out),       32'h0040);
        chk("ext_h4_valid", 32'(bus.out_valid), 32'h1);
        tick(); tick(); tick();
        chk("ext_end", 32'(bus.out), 32'h0);

        // Abort with enable low in hold cycle 2
        bus.in = 4'hF; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("abort_h1", 32'(bus.out), 32'h4000);
        tick();
        bus.enable = 1'b0;
        #1;
        chk("abort_ready_low", 32'(bus.in_ready), 32'h0);
        tick();
        chk("abort_out",   32'(bus.out),       32'h0);
        chk("abort_valid", 32'(bus.out_valid), 32'h0);
        chk("abort_ready", 32'(bus.in_ready),  32'h0);
        bus.in = 4'h4; bus.in_valid = 1'b1;
        tick();
        chk("dis_no_accept", 32'(bus.out_valid), 32'h0);
        bus.in_valid = 1'b0;
        bus.enable   = 1'b1;
        #1;
        chk("reen_ready", 32'(bus.in_ready), 32'h1);

        // Asynchronous reset mid-hold
        bus.in = 4'h8; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("rst_mid_h1", 32'(bus.out), 32'h0080);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out",     32'(bus.out),       32'h0);
        chk("rst_mid_valid",   32'(bus.out_valid), 32'h0);
        chk("rst_mid_overrun", 32'(bus.overrun),   32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.in = 4'h2; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("post_rst_out",   32'(bus.out),       32'h0002);
        chk("post_rst_valid", 32'(bus.out_valid), 32'h1);
        tick(); tick(); tick();
        chk("post_rst_end", 32'(bus.out), 32'h0);

        // Unknown code decodes to no line but is still a transaction
        bus.in = 4'bxxxx; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.in       = 4'h0;
        chk("x_out",   32'(bus.out),       32'h0);
        chk("x_valid", 32'(bus.out_valid), 32'h1);
        tick(); tick(); tick();
        chk("x_end_valid", 32'(bus.out_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
